// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Requester ids double as the grant bit index.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEPTH_DEF = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker with its last-winner register.
// On contention the requester that did not win last time is picked.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o  = req_i;
    last_d = last_q;
    if (req_i == 2'b11) begin
      gnt_o = (last_q == REQ_B) ? 2'b01 : 2'b10;
    end
    if (en_i && (|req_i)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core LSU (A) and debug loader (B).
// Grant in IDLE, memory access in ACCESS, registered response in RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_err,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_err,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH);

  state_e                state_q, state_d;
  logic                  we_q, id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic                  a_err_q, b_err_q;

  logic                  take;
  logic [1:0]            pick;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd;

  assign take     = (state_q == IDLE) && !rst;
  assign in_range = addr_q < LIMIT;
  assign rd       = (!we_q && in_range) ? mem_rdata : '0;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i ({b_req, a_req}),
    .en_i  (take),
    .gnt_o (pick)
  );

  always_comb begin
    state_d   = state_q;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    a_rvalid  = 1'b0;
    b_rvalid  = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (|pick) begin
          a_gnt   = pick[0] & ~rst;
          b_gnt   = pick[1] & ~rst;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_write = we_q & in_range & ~rst;
        mem_read  = ~we_q & in_range;
        state_d   = RESP;
      end
      RESP: begin
        // in-range stores complete silently
        a_rvalid = ~rst & (id_q == REQ_A) & (~we_q | ~in_range);
        b_rvalid = ~rst & (id_q == REQ_B) & (~we_q | ~in_range);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      id_q      <= REQ_A;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take && (|pick)) begin
        id_q    <= pick[1];
        we_q    <= pick[1] ? b_we : a_we;
        addr_q  <= pick[1] ? b_addr : a_addr;
        wdata_q <= pick[1] ? b_wdata : a_wdata;
      end
      if (state_q == ACCESS) begin
        if (id_q == REQ_A) begin
          a_rdata_q <= rd;
          a_err_q   <= ~in_range;
        end else begin
          b_rdata_q <= rd;
          b_err_q   <= ~in_range;
        end
      end
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign a_err   = a_err_q;
  assign b_err   = b_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random transactions against a transaction-level model.
// Model: pending request per port, round-robin winner, golden memory.
module tb_dmem_arbiter;

  typedef struct {
    bit          v;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tb_mem [0:63] = '{default: 32'h0};
  logic [31:0] ref_mem [0:63];

  int          checks = 0;
  int          errors = 0;
  txn_t        pend [2];
  int          last_w;
  logic [31:0] exp_rd [2];
  bit          exp_er [2];

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .b_err     (b_err),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr[5:0]] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_ports();
    a_req   = pend[0].v;
    a_we    = pend[0].we;
    a_addr  = pend[0].addr;
    a_wdata = pend[0].wdata;
    b_req   = pend[1].v;
    b_we    = pend[1].we;
    b_addr  = pend[1].addr;
    b_wdata = pend[1].wdata;
  endtask

  task automatic set_pend(input int p, input bit we,
                          input logic [31:0] addr, input logic [31:0] d);
    pend[p].v     = 1'b1;
    pend[p].we    = we;
    pend[p].addr  = addr;
    pend[p].wdata = d;
  endtask

  task automatic model_reset();
    last_w    = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_er[0] = 1'b0;
    exp_er[1] = 1'b0;
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, "_ctl"}, {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write, mem_read},
        32'h0);
    chk({tag, "_maddr"}, mem_addr, 32'h0);
    chk({tag, "_mwdata"}, mem_wdata, 32'h0);
  endtask

  // Called at an IDLE-cycle negedge; returns at the next IDLE-cycle negedge.
  task automatic round();
    int          w;
    txn_t        t;
    bit          inr;
    bit          rv;
    logic [31:0] rdv;
    drive_ports();
    #1;
    if (!pend[0].v && !pend[1].v) begin
      check_idle_outs("noreq");
      @(negedge clk);
      return;
    end
    if (pend[0].v && pend[1].v) w = (last_w == 1) ? 0 : 1;
    else w = pend[0].v ? 0 : 1;
    chk("gnt_a", a_gnt, w == 0);
    chk("gnt_b", b_gnt, w == 1);
    last_w    = w;
    t         = pend[w];
    pend[w].v = 1'b0;
    inr       = t.addr < 32;

    @(negedge clk);
    drive_ports();
    #1;
    chk("acc_gnt", {a_gnt, b_gnt}, 32'h0);
    chk("acc_rvalid", {a_rvalid, b_rvalid}, 32'h0);
    chk("mem_write", mem_write, t.we && inr);
    chk("mem_read", mem_read, !t.we && inr);
    if (inr) chk("mem_addr", mem_addr, t.addr);
    if (inr && t.we) chk("mem_wdata", mem_wdata, t.wdata);
    if (inr && t.we) ref_mem[t.addr[5:0]] = t.wdata;

    @(negedge clk);
    #1;
    rv        = !t.we || !inr;
    rdv       = (!t.we && inr) ? ref_mem[t.addr[5:0]] : 32'h0;
    exp_rd[w] = rdv;
    exp_er[w] = !inr;
    chk("rvalid_a", a_rvalid, (w == 0) && rv);
    chk("rvalid_b", b_rvalid, (w == 1) && rv);
    chk("rdata_a", a_rdata, exp_rd[0]);
    chk("rdata_b", b_rdata, exp_rd[1]);
    chk("err_a", a_err, exp_er[0]);
    chk("err_b", b_err, exp_er[1]);
    chk("resp_mem", {mem_write, mem_read, a_gnt, b_gnt}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    model_reset();
    rst = 1'b1;
    drive_ports();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outs("reset");
    chk("reset_rdata", {a_rdata[15:0], b_rdata[15:0]}, 32'h0);
    chk("reset_err", {a_err, b_err}, 32'h0);
    @(negedge clk);

    // contention from reset: A,B,A,B
    for (int i = 0; i < 4; i++) begin
      if (!pend[0].v) set_pend(0, 1'b1, 32'(10 + i), 32'hA000_0000 + i);
      if (!pend[1].v) set_pend(1, 1'b0, 32'(10 + i), 32'h0);
      round();
    end
    while (pend[0].v || pend[1].v) round();

    set_pend(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    round();
    set_pend(1, 1'b0, 32'd5, 32'h0);
    round();
    chk("b_load5", b_rdata, 32'hDEAD_BEEF);

    set_pend(0, 1'b0, 32'd32, 32'h0);
    round();
    chk("a_err32", a_err, 1'b1);

    set_pend(0, 1'b1, 32'd0, 32'h0000_A5A5);
    round();
    set_pend(0, 1'b0, 32'd0, 32'h0);
    round();
    chk("a_load0", a_rdata, 32'h0000_A5A5);

    // B raises and drops its request while A is busy
    set_pend(0, 1'b0, 32'd3, 32'h0);
    drive_ports();
    #1;
    chk("drop_gnt_a", a_gnt, 1'b1);
    last_w    = 0;
    pend[0].v = 1'b0;
    @(negedge clk);
    set_pend(1, 1'b1, 32'd4, 32'h5555_0000);
    drive_ports();
    #1;
    chk("drop_acc_b", b_gnt, 1'b0);
    @(negedge clk);
    pend[1].v = 1'b0;
    drive_ports();
    #1;
    chk("drop_resp_b", {b_gnt, b_rvalid}, 32'h0);
    chk("drop_a_rdata", a_rdata, ref_mem[3]);
    exp_rd[0] = ref_mem[3];
    exp_er[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_idle_outs("drop_idle");
    end
    chk("drop_mem4", tb_mem[4], ref_mem[4]);
    @(negedge clk);

    // reset during ACCESS of a store
    set_pend(0, 1'b1, 32'd7, 32'h0000_1234);
    drive_ports();
    #1;
    chk("rst_gnt", a_gnt, 1'b1);
    pend[0].v = 1'b0;
    @(negedge clk);
    drive_ports();
    rst = 1'b1;
    #1;
    chk("rst_nowrite", mem_write, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_idle_outs("rst_next");
    chk("rst_rdata", {a_rdata[15:0], b_rdata[15:0]}, 32'h0);
    chk("rst_mem7", tb_mem[7], ref_mem[7]);
    @(negedge clk);
    #1;
    chk("rst_norv", a_rvalid, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p].v && $urandom_range(1, 0) == 1) begin
          logic [31:0] ad;
          ad = ($urandom_range(7, 0) == 0) ? {1'b1, 31'($urandom)}
                                           : 32'($urandom_range(35, 0));
          set_pend(p, 1'($urandom), ad, $urandom);
        end
      end
      round();
    end
    for (int i = 0; i < 32; i++) begin
      set_pend(0, 1'b0, 32'(i), 32'h0);
      round();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
